// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared definitions for the main-RAM arbiter:
//   - RAM geometry (13-bit byte address, 8-bit data: 8 KB main RAM)
//   - slot state encoding (IDLE -> ACCESS -> DATA, 2'd3 is illegal)
//   - owner encoding for the request in flight
//   - saturating increment used by the starvation counter
package ram_arbiter_pkg;

    localparam int ADDR_WIDTH = 13;
    localparam int DATA_WIDTH = 8;
    localparam int CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DATA   = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DMA = 1'b1
    } owner_t;

    // Increment by one, sticking at lim once reached.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] value,
        input logic [CNT_WIDTH-1:0] lim
    );
        logic [CNT_WIDTH-1:0] result;
        if (value >= lim) begin
            result = lim;
        end else begin
            result = value + 4'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// Bundles the CPU port, the DMA port and the RAM-side signals of the arbiter.
//   master : requesters plus the RAM instance (drives req/we/addr/din and ram_dout)
//   slave  : the arbiter (drives acks, read data and the RAM address/w_en/din)
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_din;
    logic [DATA_WIDTH-1:0] cpu_dout;
    logic                  cpu_ack;

    logic                  dma_req;
    logic                  dma_we;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_din;
    logic [DATA_WIDTH-1:0] dma_dout;
    logic                  dma_ack;

    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_w_en;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack,
        output dma_req, dma_we, dma_addr, dma_din,
        input  dma_dout, dma_ack,
        input  ram_address, ram_w_en, ram_din,
        output ram_dout
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack,
        input  dma_req, dma_we, dma_addr, dma_din,
        output dma_dout, dma_ack,
        output ram_address, ram_w_en, ram_din,
        input  ram_dout
    );

endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares the single-port 8 KB main RAM between the 6502 CPU port and a DMA port.
// CPU has fixed priority; after MAX_WAIT consecutive CPU grants with DMA waiting,
// DMA is forced through. Every access takes a 3-cycle slot IDLE -> ACCESS -> DATA,
// with the owner's ack (and read data) registered into the following IDLE cycle.
// Ports:
//   clk  - system clock, all state on posedge
//   rst  - asynchronous active-high reset
//   bus  - ram_arbiter_if.slave: CPU/DMA request ports and RAM address/w_en/din/dout
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    ram_arbiter_if.slave   bus
);

    localparam logic [CNT_WIDTH-1:0] MAX_WAIT_C = CNT_WIDTH'(MAX_WAIT);

    state_t                state_q,       state_d;
    owner_t                owner_q,       owner_d;
    logic                  req_we_q,      req_we_d;
    logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
    logic [DATA_WIDTH-1:0] ram_din_q,     ram_din_d;
    logic                  ram_w_en_q,    ram_w_en_d;
    logic                  cpu_ack_q,     cpu_ack_d;
    logic                  dma_ack_q,     dma_ack_d;
    logic [DATA_WIDTH-1:0] cpu_dout_q,    cpu_dout_d;
    logic [DATA_WIDTH-1:0] dma_dout_q,    dma_dout_d;
    logic [CNT_WIDTH-1:0]  starve_cnt_q,  starve_cnt_d;

    logic grant_s;
    logic dma_wins_s;

    // Arbitration decision for this edge (only meaningful in IDLE).
    always_comb begin
        grant_s    = 1'b0;
        dma_wins_s = 1'b0;
        if (state_q == S_IDLE) begin
            grant_s    = bus.cpu_req | bus.dma_req;
            dma_wins_s = bus.dma_req & (~bus.cpu_req | (starve_cnt_q == MAX_WAIT_C));
        end else begin
            grant_s    = 1'b0;
            dma_wins_s = 1'b0;
        end
    end

    // Slot sequencing, request latch, read-data capture and ack generation.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        req_we_d      = req_we_q;
        ram_address_d = ram_address_q;
        ram_din_d     = ram_din_q;
        ram_w_en_d    = 1'b0;
        cpu_ack_d     = 1'b0;
        dma_ack_d     = 1'b0;
        cpu_dout_d    = cpu_dout_q;
        dma_dout_d    = dma_dout_q;

        case (state_q)
            S_IDLE: begin
                if (grant_s) begin
                    state_d = S_ACCESS;
                    // ram_w_en is loaded here so it is high exactly during ACCESS.
                    if (dma_wins_s) begin
                        owner_d       = OWNER_DMA;
                        req_we_d      = bus.dma_we;
                        ram_address_d = bus.dma_addr;
                        ram_din_d     = bus.dma_din;
                        ram_w_en_d    = bus.dma_we;
                    end else begin
                        owner_d       = OWNER_CPU;
                        req_we_d      = bus.cpu_we;
                        ram_address_d = bus.cpu_addr;
                        ram_din_d     = bus.cpu_din;
                        ram_w_en_d    = bus.cpu_we;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                state_d = S_IDLE;
                // RAM output now holds the word sampled at the end of ACCESS.
                if (owner_q == OWNER_DMA) begin
                    dma_ack_d = 1'b1;
                    if (!req_we_q) begin
                        dma_dout_d = bus.ram_dout;
                    end else begin
                        dma_dout_d = dma_dout_q;
                    end
                end else begin
                    cpu_ack_d = 1'b1;
                    if (!req_we_q) begin
                        cpu_dout_d = bus.ram_dout;
                    end else begin
                        cpu_dout_d = cpu_dout_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Starvation counter: counts CPU grants taken while DMA is waiting.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.dma_req) begin
            starve_cnt_d = {CNT_WIDTH{1'b0}};
        end else if (grant_s && dma_wins_s) begin
            starve_cnt_d = {CNT_WIDTH{1'b0}};
        end else if (grant_s) begin
            starve_cnt_d = sat_inc(starve_cnt_q, MAX_WAIT_C);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            owner_q       <= OWNER_CPU;
            req_we_q      <= 1'b0;
            ram_address_q <= {ADDR_WIDTH{1'b0}};
            ram_din_q     <= {DATA_WIDTH{1'b0}};
            ram_w_en_q    <= 1'b0;
            cpu_ack_q     <= 1'b0;
            dma_ack_q     <= 1'b0;
            cpu_dout_q    <= {DATA_WIDTH{1'b0}};
            dma_dout_q    <= {DATA_WIDTH{1'b0}};
            starve_cnt_q  <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            req_we_q      <= req_we_d;
            ram_address_q <= ram_address_d;
            ram_din_q     <= ram_din_d;
            ram_w_en_q    <= ram_w_en_d;
            cpu_ack_q     <= cpu_ack_d;
            dma_ack_q     <= dma_ack_d;
            cpu_dout_q    <= cpu_dout_d;
            dma_dout_q    <= dma_dout_d;
            starve_cnt_q  <= starve_cnt_d;
        end
    end

    assign bus.ram_address = ram_address_q;
    assign bus.ram_din     = ram_din_q;
    assign bus.ram_w_en    = ram_w_en_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.dma_ack     = dma_ack_q;
    assign bus.cpu_dout    = cpu_dout_q;
    assign bus.dma_dout    = dma_dout_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter: drives both request ports, models the
// registered-output 8 KB RAM, and compares against hand-computed values.
module tb_ram_arbiter;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    logic [7:0] mem [0:8191];

    ram_arbiter_if bus ();

    ram_arbiter #(.MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with registered read data.
    always @(posedge clk) begin
        if (bus.ram_w_en) begin
            mem[bus.ram_address] <= bus.ram_din;
        end
        bus.ram_dout <= mem[bus.ram_address];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access from an idle arbiter; checks ACCESS-cycle RAM drive, latency,
    // the other port's ack and (for reads) the returned data.
    task automatic access(input bit is_dma, input bit we, input logic [12:0] addr,
                          input logic [7:0] din, input logic [7:0] exp, input bit drop,
                          input string tag);
        int n;
        bit got;
        if (is_dma) begin
            bus.dma_we = we; bus.dma_addr = addr; bus.dma_din = din; bus.dma_req = 1'b1;
        end else begin
            bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_din = din; bus.cpu_req = 1'b1;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 12) begin
            tick();
            n++;
            if (n == 1) begin
                check_eq({tag, " ram_address"}, 32'(bus.ram_address), 32'(addr));
                check_eq({tag, " ram_w_en"}, 32'(bus.ram_w_en), 32'(we));
            end
            got = is_dma ? bus.dma_ack : bus.cpu_ack;
        end
        check_eq({tag, " latency"}, 32'(n), 32'd3);
        check_eq({tag, " other ack"}, 32'(is_dma ? bus.cpu_ack : bus.dma_ack), 32'd0);
        if (!we) begin
            check_eq({tag, " dout"}, 32'(is_dma ? bus.dma_dout : bus.cpu_dout), 32'(exp));
        end
        if (drop) begin
            if (is_dma) bus.dma_req = 1'b0;
            else        bus.cpu_req = 1'b0;
        end
    endtask

    initial begin
        int n;
        int cpu_acks;
        int last;
        int dma_acks;
        bit dma_seen;
        bit done;

        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        rst = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0000; bus.cpu_din = 8'h00;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 13'h0000; bus.dma_din = 8'h00;
        tick();
        tick();

        // Reset state.
        check_eq("rst cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check_eq("rst dma_ack", 32'(bus.dma_ack), 32'd0);
        check_eq("rst cpu_dout", 32'(bus.cpu_dout), 32'd0);
        check_eq("rst dma_dout", 32'(bus.dma_dout), 32'd0);
        check_eq("rst ram_w_en", 32'(bus.ram_w_en), 32'd0);
        rst = 1'b0;
        tick();

        // 1. Reset mid-ACCESS of a CPU write: write abandoned, outputs cleared at once.
        bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0100; bus.cpu_din = 8'hAA; bus.cpu_req = 1'b1;
        tick();
        check_eq("t1 w_en in access", 32'(bus.ram_w_en), 32'd1);
        check_eq("t1 addr in access", 32'(bus.ram_address), 32'h0100);
        #1 rst = 1'b1;
        #1;
        check_eq("t1 w_en after rst", 32'(bus.ram_w_en), 32'd0);
        check_eq("t1 addr after rst", 32'(bus.ram_address), 32'd0);
        check_eq("t1 din after rst", 32'(bus.ram_din), 32'd0);
        bus.cpu_req = 1'b0;
        tick();
        tick();
        check_eq("t1 no cpu_ack", 32'(bus.cpu_ack), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("t1 write dropped", 32'(mem[13'h0100]), 32'h00);
        access(1'b0, 1'b0, 13'h0100, 8'h00, 8'h00, 1'b1, "t1 readback");

        // 2. CPU write then read.
        access(1'b0, 1'b1, 13'h0300, 8'h5A, 8'h00, 1'b1, "t2 cpu wr");
        check_eq("t2 dout held on write", 32'(bus.cpu_dout), 32'h00);
        access(1'b0, 1'b0, 13'h0300, 8'h00, 8'h5A, 1'b1, "t2 cpu rd");
        tick();

        // 3. DMA alone at the top byte.
        access(1'b1, 1'b1, 13'h1FFF, 8'hC3, 8'h00, 1'b1, "t3 dma wr");
        access(1'b1, 1'b0, 13'h1FFF, 8'h00, 8'hC3, 1'b1, "t3 dma rd");
        check_eq("t3 cpu_dout kept", 32'(bus.cpu_dout), 32'h5A);
        tick();

        // 4. Both requesting continuously: four CPU grants, then DMA, then CPU.
        bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0300; bus.cpu_req = 1'b1;
        bus.dma_we = 1'b0; bus.dma_addr = 13'h1FFF; bus.dma_req = 1'b1;
        n = 0; cpu_acks = 0; last = 0; dma_seen = 1'b0; done = 1'b0;
        while (!done && n < 60) begin
            tick();
            n++;
            if (bus.cpu_ack && bus.dma_ack) check_eq("t4 acks overlap", 32'd1, 32'd0);
            if (bus.dma_ack) begin
                check_eq("t4 cpu acks before dma", 32'(cpu_acks), 32'd4);
                check_eq("t4 dma gap", 32'(n - last), 32'd3);
                check_eq("t4 dma_dout", 32'(bus.dma_dout), 32'hC3);
                last = n;
                dma_seen = 1'b1;
                bus.dma_req = 1'b0;
            end
            if (bus.cpu_ack) begin
                cpu_acks++;
                check_eq("t4 cpu gap", 32'(n - last), 32'd3);
                check_eq("t4 cpu_dout", 32'(bus.cpu_dout), 32'h5A);
                last = n;
                if (dma_seen) begin
                    bus.cpu_req = 1'b0;
                    done = 1'b1;
                end
            end
        end
        check_eq("t4 completed", 32'(done), 32'd1);
        check_eq("t4 cpu ack total", 32'(cpu_acks), 32'd5);
        tick();

        // 5. Back-to-back CPU reads with req held through each ack.
        access(1'b0, 1'b1, 13'h0010, 8'h11, 8'h00, 1'b1, "t5 wr0");
        access(1'b0, 1'b1, 13'h0011, 8'h22, 8'h00, 1'b1, "t5 wr1");
        access(1'b0, 1'b1, 13'h0012, 8'h33, 8'h00, 1'b1, "t5 wr2");
        access(1'b0, 1'b0, 13'h0010, 8'h00, 8'h11, 1'b0, "t5 b2b0");
        access(1'b0, 1'b0, 13'h0011, 8'h00, 8'h22, 1'b0, "t5 b2b1");
        access(1'b0, 1'b0, 13'h0012, 8'h00, 8'h33, 1'b1, "t5 b2b2");
        tick();

        // 6. DMA gives up before being granted.
        bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0400; bus.cpu_din = 8'h77; bus.cpu_req = 1'b1;
        bus.dma_we = 1'b1; bus.dma_addr = 13'h0500; bus.dma_din = 8'h99; bus.dma_req = 1'b1;
        tick();
        check_eq("t6 cpu granted", 32'(bus.ram_address), 32'h0400);
        check_eq("t6 starve after grant", 32'(dut.starve_cnt_q), 32'd1);
        bus.dma_req = 1'b0;
        tick();
        check_eq("t6 starve cleared", 32'(dut.starve_cnt_q), 32'd0);
        tick();
        check_eq("t6 cpu_ack", 32'(bus.cpu_ack), 32'd1);
        bus.cpu_req = 1'b0;
        dma_acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.dma_ack) dma_acks++;
        end
        check_eq("t6 no dma_ack", 32'(dma_acks), 32'd0);
        check_eq("t6 no dma write", 32'(mem[13'h0500]), 32'h00);
        check_eq("t6 cpu write", 32'(mem[13'h0400]), 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
